// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared SPI mode encodings, FSM state type and edge-role helper
package spi_pkg;

    typedef enum logic [1:0] {
        SPI_MODE0 = 2'd0,
        SPI_MODE1 = 2'd1,
        SPI_MODE2 = 2'd2,
        SPI_MODE3 = 2'd3
    } spi_mode_e;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } spi_state_e;

    // An sclk transition is a leading edge when it leaves the idle level set by CPOL.
    function automatic logic is_lead(input logic new_level, input logic cpol);
        return new_level != cpol;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - multi-stage synchroniser with rise/fall pulses on the synced level
module spi_sync_edge #(
    parameter int STAGES    = 2,
    parameter bit RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] q;
    logic              prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            q    <= {STAGES{RESET_VAL}};
            prev <= RESET_VAL;
        end else begin
            q    <= {q[STAGES-2:0], din};
            prev <= q[STAGES-1];
        end
    end

    assign sync = q[STAGES-1];
    assign rise = q[STAGES-1] & ~prev;
    assign fall = ~q[STAGES-1] & prev;

endmodule

// File: rtl/spi_slave_sync.sv
// rtl/spi_slave_sync.sv - SPI target sampled entirely in the system clock domain
module spi_slave_sync
    import spi_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter bit               CPOL        = 1'b0,
    parameter bit               CPHA        = 1'b0,
    parameter bit               MSB_FIRST   = 1'b1,
    parameter int               SYNC_STAGES = 2,
    parameter logic [WIDTH-1:0] FILL        = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sclk,
    input  logic             cs_n,
    input  logic             mosi,
    output logic             miso,
    output logic             miso_oe,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    input  logic             rx_ready,
    output logic             rx_overrun,
    output logic             tx_underrun,
    output logic             frame_abort
);

    localparam int CW = $clog2(WIDTH);

    spi_state_e             state;
    logic [CW-1:0]          bit_cnt;
    logic [WIDTH-1:0]       rx_shift, rx_word, rx_next;
    logic [WIDTH-1:0]       tx_shift, hold_data, load_word;
    logic                   hold_full, load_pend, deliver, load_now, wr;
    logic                   sclk_s, sclk_rise, sclk_fall, sclk_edge;
    logic                   cs_s, cs_rise, cs_fall;
    logic                   lead, trail, sample_edge, shift_edge, mosi_s;
    logic [SYNC_STAGES-1:0] mosi_q;

    function automatic logic head(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? (w << 1) : (w >> 1);
    endfunction

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(CPOL)) u_sclk_sync (
        .clk(clk), .rst(rst), .din(sclk), .sync(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
        .clk(clk), .rst(rst), .din(cs_n), .sync(cs_s), .rise(cs_rise), .fall(cs_fall)
    );

    // mosi shares the sclk synchroniser depth so data and edge stay aligned.
    always_ff @(posedge clk) begin
        if (rst) mosi_q <= '0;
        else     mosi_q <= {mosi_q[SYNC_STAGES-2:0], mosi};
    end

    assign mosi_s      = mosi_q[SYNC_STAGES-1];
    assign sclk_edge   = sclk_rise | sclk_fall;
    assign lead        = sclk_edge & is_lead(sclk_s, CPOL);
    assign trail       = sclk_edge & ~is_lead(sclk_s, CPOL);
    assign sample_edge = CPHA ? trail : lead;
    assign shift_edge  = CPHA ? lead : trail;
    assign miso_oe     = ~cs_s;
    assign wr          = tx_valid & tx_ready;
    assign load_word   = hold_full ? hold_data : FILL;
    assign rx_next     = MSB_FIRST ? {rx_shift[WIDTH-2:0], mosi_s} : {mosi_s, rx_shift[WIDTH-1:1]};
    assign load_now    = (state == ST_IDLE && cs_fall) ||
                         (state == ST_ACTIVE && !cs_rise && shift_edge && load_pend);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            bit_cnt     <= '0;
            rx_shift    <= '0;
            rx_word     <= '0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            tx_shift    <= '0;
            hold_data   <= '0;
            hold_full   <= 1'b0;
            tx_ready    <= 1'b0;
            load_pend   <= 1'b0;
            deliver     <= 1'b0;
            miso        <= 1'b0;
            rx_overrun  <= 1'b0;
            tx_underrun <= 1'b0;
            frame_abort <= 1'b0;
        end else begin
            rx_overrun  <= 1'b0;
            frame_abort <= 1'b0;
            deliver     <= 1'b0;
            tx_underrun <= load_now && !hold_full;

            if (wr) begin
                hold_data <= tx_data;
                hold_full <= 1'b1;
            end else if (load_now) begin
                hold_full <= 1'b0;
            end
            tx_ready <= !(wr || (hold_full && !load_now));

            if (deliver) begin
                if (rx_valid && !rx_ready) begin
                    rx_overrun <= 1'b1;
                end else begin
                    rx_data  <= rx_word;
                    rx_valid <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (cs_fall) begin
                        state     <= ST_ACTIVE;
                        bit_cnt   <= '0;
                        load_pend <= 1'b0;
                        // CPHA=1 holds the first bit back until the first leading edge.
                        if (!CPHA) begin
                            tx_shift <= advance(load_word);
                            miso     <= head(load_word);
                        end else begin
                            tx_shift <= load_word;
                        end
                    end
                end
                ST_ACTIVE: begin
                    if (cs_rise) begin
                        state       <= ST_IDLE;
                        bit_cnt     <= '0;
                        load_pend   <= 1'b0;
                        miso        <= 1'b0;
                        frame_abort <= (bit_cnt != '0);
                    end else begin
                        if (sample_edge) begin
                            rx_shift <= rx_next;
                            if (bit_cnt == CW'(WIDTH - 1)) begin
                                bit_cnt   <= '0;
                                rx_word   <= rx_next;
                                deliver   <= 1'b1;
                                load_pend <= 1'b1;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                        if (shift_edge) begin
                            if (load_pend) begin
                                tx_shift  <= advance(load_word);
                                miso      <= head(load_word);
                                load_pend <= 1'b0;
                            end else begin
                                tx_shift <= advance(tx_shift);
                                miso     <= head(tx_shift);
                            end
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
